// File: rtl/key_provisioner_if.sv
// key_provisioner_if: start/serial-load handshake and key delivery bundle for key_provisioner
interface key_provisioner_if #(
    parameter int KEY_W = 8
);
    logic             start;
    logic             key_svalid;
    logic             key_sdata;
    logic [KEY_W-1:0] keyinput;
    logic             key_ready;
    logic             key_err;
    logic             busy;
    logic             locked_out;
    modport master (
        output start, key_svalid, key_sdata,
        input  keyinput, key_ready, key_err, busy, locked_out
    );
    modport slave (
        input  start, key_svalid, key_sdata,
        output keyinput, key_ready, key_err, busy, locked_out
    );
endinterface

// File: rtl/key_provisioner.sv
// key_provisioner: serial key loader with even-parity check, idle timeout and failure lockout
module key_provisioner #(
    parameter int               KEY_W    = 8,
    parameter int               TIMEOUT  = 16,
    parameter int               MAX_FAIL = 3,
    parameter logic [KEY_W-1:0] DECOY    = '0
) (
    input logic clk,
    input logic rst,
    key_provisioner_if.slave io
);
    localparam int BW = $clog2(KEY_W + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, ARMED, LOCKOUT} state_t;
    state_t           state, next;
    logic [BW-1:0]    bit_cnt;
    logic [IW-1:0]    idle_cnt;
    logic [FW-1:0]    fail_cnt, fail_inc;
    logic [KEY_W-1:0] shadow;
    logic             parity, pass, fail_ev, timeout, accept;
    assign accept        = state == LOAD && io.key_svalid;
    assign timeout       = state == LOAD && !io.key_svalid && idle_cnt == IW'(TIMEOUT - 1);
    assign pass          = ~(^shadow ^ parity);
    assign fail_inc      = fail_cnt == FW'(MAX_FAIL) ? fail_cnt : fail_cnt + 1'b1;
    assign io.busy       = state == LOAD || state == CHECK;
    assign io.locked_out = state == LOCKOUT;
    // Next state; a failed attempt diverts to IDLE or, once the limit is hit, LOCKOUT
    always_comb begin
        next    = state;
        fail_ev = 1'b0;
        case (state)
            IDLE:    next = io.start ? LOAD : IDLE;
            LOAD:    if (accept && bit_cnt == BW'(KEY_W)) next = CHECK; else fail_ev = timeout;
            CHECK:   if (pass) next = ARMED; else fail_ev = 1'b1;
            ARMED:   next = io.start ? LOAD : ARMED;
            default: next = LOCKOUT;
        endcase
        if (fail_ev) next = fail_inc == FW'(MAX_FAIL) ? LOCKOUT : IDLE;
    end
    // State, counters, shadow capture and registered outputs; the locking failure shows only as locked_out
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            fail_cnt    <= '0;
            shadow      <= '0;
            parity      <= 1'b0;
            io.keyinput <= DECOY;
            io.key_ready <= 1'b0;
            io.key_err  <= 1'b0;
        end else begin
            state        <= next;
            io.key_err   <= fail_ev && next != LOCKOUT;
            io.key_ready <= next == ARMED;
            io.keyinput  <= next == ARMED ? (state == CHECK ? shadow : io.keyinput) : DECOY;
            if (fail_ev) fail_cnt <= fail_inc;
            else if (state == CHECK) fail_cnt <= '0;
            if (next == LOAD && state != LOAD) begin
                bit_cnt  <= '0;
                idle_cnt <= '0;
                shadow   <= '0;
                parity   <= 1'b0;
            end else if (accept) begin
                bit_cnt  <= bit_cnt + 1'b1;
                idle_cnt <= '0;
                if (bit_cnt < BW'(KEY_W)) shadow <= shadow | (KEY_W'(io.key_sdata) << bit_cnt);
                else parity <= io.key_sdata;
            end else if (state == LOAD) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_key_provisioner.sv
// tb_key_provisioner: directed scoreboard bench for key_provisioner
module tb_key_provisioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [9:0] sb[$];
    key_provisioner_if #(.KEY_W(8)) bus();
    key_provisioner dut (.clk(clk), .rst(rst), .io(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic start_load();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic send_bits(input logic [7:0] k, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.key_svalid = 1'b1;
            bus.key_sdata  = k[i];
            tick();
        end
        bus.key_svalid = 1'b0;
        bus.key_sdata  = 1'b0;
    endtask
    task automatic send_par(input logic p);
        bus.key_svalid = 1'b1;
        bus.key_sdata  = p;
        tick();
        bus.key_svalid = 1'b0;
        bus.key_sdata  = 1'b0;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    task automatic full_load(input logic [7:0] k, input logic bad);
        sb.push_back(bad ? {2'd1, 8'h00} : {2'd0, k});
        start_load();
        send_bits(k, 0, 7);
        send_par((^k) ^ bad);
    endtask
    task automatic expect_out(input string tag);
        logic [9:0] obs, exp;
        logic [1:0] kind;
        int n = 0;
        while (!(bus.key_err || bus.key_ready || bus.locked_out) && n < 40) begin
            tick();
            n++;
        end
        kind = bus.key_err ? 2'd1 : bus.locked_out ? 2'd2 : bus.key_ready ? 2'd0 : 2'd3;
        obs  = {kind, bus.keyinput};
        exp  = sb.size() != 0 ? sb.pop_front() : 10'h3ff;
        chk(tag, 32'(obs), 32'(exp));
        if (bus.key_err) begin
            tick();
            chk({tag, "_pulse_len"}, 32'(bus.key_err), 32'd0);
            chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        end
    endtask
    task automatic chk_reset_outs(input string tag);
        chk({tag, "_key"}, 32'(bus.keyinput), 32'h00);
        chk({tag, "_rdy"}, 32'(bus.key_ready), 32'd0);
        chk({tag, "_err"}, 32'(bus.key_err), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_lock"}, 32'(bus.locked_out), 32'd0);
    endtask
    initial begin
        bus.start      = 1'b0;
        bus.key_svalid = 1'b0;
        bus.key_sdata  = 1'b0;
        idle(3);
        rst = 1'b0;
        chk_reset_outs("reset");
        // exact timing of a good 0xA5 load
        sb.push_back({2'd0, 8'hA5});
        start_load();
        chk("c1_busy", 32'(bus.busy), 32'd1);
        send_bits(8'hA5, 0, 7);
        chk("c9_busy", 32'(bus.busy), 32'd1);
        send_par(1'b0);
        chk("c10_check_busy", 32'(bus.busy), 32'd1);
        chk("c10_not_ready", 32'(bus.key_ready), 32'd0);
        tick();
        chk("c11_busy", 32'(bus.busy), 32'd0);
        expect_out("arm_a5");
        bus.key_svalid = 1'b1;
        bus.key_sdata  = 1'b0;
        idle(4);
        bus.key_svalid = 1'b0;
        chk("armed_hold_key", 32'(bus.keyinput), 32'hA5);
        chk("armed_hold_rdy", 32'(bus.key_ready), 32'd1);
        // re-arm from ARMED: key withdrawn in the first LOAD cycle
        sb.push_back({2'd0, 8'h3C});
        start_load();
        chk("rearm_decoy", 32'(bus.keyinput), 32'h00);
        chk("rearm_rdy", 32'(bus.key_ready), 32'd0);
        chk("rearm_busy", 32'(bus.busy), 32'd1);
        send_bits(8'h3C, 0, 7);
        send_par(1'b0);
        expect_out("arm_3c");
        // bad parity from ARMED
        full_load(8'hA5, 1'b1);
        expect_out("bad_par1");
        chk("bad_par1_key", 32'(bus.keyinput), 32'h00);
        // a valid bit on the 16th idle cycle wins over the timeout
        sb.push_back({2'd0, 8'h5B});
        start_load();
        send_bits(8'h5B, 0, 2);
        idle(15);
        chk("idle15_busy", 32'(bus.busy), 32'd1);
        send_bits(8'h5B, 3, 7);
        chk("late_bit_no_err", 32'(bus.key_err), 32'd0);
        send_par(^8'h5B);
        expect_out("arm_5b_late");
        // genuine timeout: 16 idle cycles
        sb.push_back({2'd1, 8'h00});
        start_load();
        send_bits(8'h5B, 0, 2);
        idle(15);
        chk("to_pre_err", 32'(bus.key_err), 32'd0);
        tick();
        expect_out("timeout");
        // fail count now 1 (timeout); bad -> 2, good clears it
        full_load(8'h11, 1'b1);
        expect_out("bad_par2");
        full_load(8'h96, 1'b0);
        expect_out("arm_96_clear");
        full_load(8'h0F, 1'b1);
        expect_out("bad_a");
        full_load(8'hF0, 1'b1);
        expect_out("bad_b");
        chk("not_locked_yet", 32'(bus.locked_out), 32'd0);
        sb.push_back({2'd2, 8'h00});
        start_load();
        send_bits(8'h81, 0, 7);
        send_par(1'b1);
        expect_out("lockout");
        chk("lock_err", 32'(bus.key_err), 32'd0);
        bus.start      = 1'b1;
        bus.key_svalid = 1'b1;
        bus.key_sdata  = 1'b1;
        idle(12);
        bus.start      = 1'b0;
        bus.key_svalid = 1'b0;
        chk("lock_hold", 32'(bus.locked_out), 32'd1);
        chk("lock_busy", 32'(bus.busy), 32'd0);
        chk("lock_err2", 32'(bus.key_err), 32'd0);
        chk("lock_rdy", 32'(bus.key_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outs("unlock");
        // reset in the middle of a load
        start_load();
        send_bits(8'hE7, 0, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outs("midload");
        idle(2);
        chk("midload_stays_idle", 32'(bus.busy), 32'd0);
        full_load(8'hA5, 1'b0);
        expect_out("arm_after_rst");
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_provisioner.md
KEY_PROVISIONER -- requirements
Module: key_provisioner

Interface
REQ-001 Parameter KEY_W, default 8, width of the delivered key bus.
REQ-002 Parameter TIMEOUT, default 16, maximum consecutive idle cycles allowed during serial load.
REQ-003 Parameter MAX_FAIL, default 3, failed load attempts before permanent lockout.
REQ-004 Parameter DECOY, default 0 (KEY_W bits), value driven on the key bus whenever no key is armed.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request a new key load; sampled in IDLE and ARMED only.
REQ-008 key_svalid  input  1  serial key bit valid this cycle.
REQ-009 key_sdata  input  1  serial key bit; key LSB-first, then one even-parity bit.
REQ-010 keyinput  output  KEY_W  key delivered to the locked FSM; registered.
REQ-011 key_ready  output  1  keyinput holds a verified key; registered.
REQ-012 key_err  output  1  one-cycle pulse per failed attempt (parity or timeout).
REQ-013 busy  output  1  high in LOAD and CHECK.
REQ-014 locked_out  output  1  high in LOCKOUT.

Function
REQ-015 States SHALL be IDLE, LOAD, CHECK, ARMED and LOCKOUT, all registered.
REQ-016 IDLE: start=1 SHALL enter LOAD next cycle, clear the bit counter, the idle counter and the shadow register.
REQ-017 LOAD: each cycle with key_svalid=1 SHALL accept key_sdata; bits 0..KEY_W-1 go to shadow[i]; bit KEY_W is the parity bit.
REQ-018 On acceptance of the parity bit the FSM SHALL enter CHECK next cycle.
REQ-019 LOAD: the idle counter SHALL clear on every valid bit and increment otherwise; reaching TIMEOUT SHALL count as a failed attempt.
REQ-020 CHECK lasts exactly one cycle; pass = XOR of the KEY_W shadow bits and the parity bit is 0.
REQ-021 Pass: next state ARMED; keyinput=shadow and key_ready=1 from the ARMED cycle; fail counter cleared.
REQ-022 Failure (parity or timeout): key_err=1 for one cycle, fail counter +1; the next state is LOCKOUT if the counter reaches MAX_FAIL, else IDLE.
REQ-023 ARMED: keyinput and key_ready SHALL hold; start=1 SHALL enter LOAD, and keyinput=DECOY and key_ready=0 in that LOAD cycle.
REQ-024 Outside ARMED, keyinput SHALL equal DECOY and key_ready SHALL be 0.
REQ-025 start SHALL be ignored in LOAD, CHECK and LOCKOUT; key_svalid SHALL be ignored outside LOAD.
REQ-026 LOCKOUT SHALL be exited only by rst; key_err=0 and locked_out=1 while in LOCKOUT.
REQ-027 Fail counter width = clog2(MAX_FAIL+1); it SHALL saturate, never wrap.
REQ-028 If a valid bit arrives in the same cycle the idle counter would reach TIMEOUT, the bit SHALL win (no timeout).

Reset
REQ-029 rst=1 SHALL force IDLE, keyinput=DECOY and key_ready=0, key_err=0, busy=0 and locked_out=0, and clear all counters and the shadow register next edge.
REQ-030 rst SHALL override every state, including mid-LOAD and LOCKOUT; partial shadow data SHALL be discarded.

Verification
REQ-031 Cycle 0 start=1; cycles 1-9 svalid=1 with bits 1,0,1,0,0,1,0,1 then parity 0 (key 0xA5) -> busy cycles 1-10, CHECK cycle 10, keyinput=0xA5 and key_ready=1 from cycle 11.
REQ-032 Same load with parity bit 1 -> key_err pulse in cycle 11, state IDLE, keyinput stays 0x00, fail count 1.
REQ-033 start then 3 bits, then svalid=0 for 16 cycles -> key_err pulse, back to IDLE; a valid bit on the 16th idle cycle instead -> no error, load continues.
REQ-034 Three consecutive bad-parity loads -> locked_out=1 after the third; further start and svalid are ignored; rst -> IDLE, locked_out=0.
REQ-035 ARMED with 0xA5, then start=1 -> keyinput=0x00 and key_ready=0 the next cycle, and a new load of 0x3C (parity 0) arms 0x3C.
REQ-036 rst asserted mid-LOAD after 5 bits -> IDLE, all outputs at reset values; a fresh full load of 0xA5 then arms correctly.
